// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, SEL codes and sequencer state encoding
package alu_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 4;

   // SEL codes equal the op codes so the output mux and this sequencer stay in step
   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SL  = 3'b101;
   localparam logic [2:0] OP_SR  = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

endpackage

// File: rtl/alu_mult_iter.sv
// rtl/alu_mult_iter.sv - shift-add multiplier datapath, one partial product per step
module alu_mult_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_next_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = WIDTH[CNT_W-1:0];

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] count_q;

   // acc_next_o is the accumulator after the current step; the parent latches it on the last one
   assign acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_o     = (count_q == CNT_ONE);

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (load_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         count_q  <= CNT_LOAD;
      end else if (step_i) begin
         acc_q    <= acc_next_o;
         mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
         count_q  <= count_q - CNT_ONE;
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU request sequencer: SEL generation plus multi-cycle mult/shift results
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       ALUOP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [2:0]       SEL,
   output logic [WIDTH-1:0] MULT_RES,
   output logic [WIDTH-1:0] SL_RES,
   output logic [WIDTH-1:0] SR_RES,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_LIM   = WIDTH[WIDTH-1:0];

   logic [1:0]       state_q;
   logic [2:0]       sel_q;
   logic [WIDTH-1:0] mult_res_q;
   logic [WIDTH-1:0] sl_res_q;
   logic [WIDTH-1:0] sr_res_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH-1:0] shadow_q;
   logic [CNT_W-1:0] scnt_q;
   logic             shl_q;

   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] imm_res;
   logic             imm_shift;
   logic             mult_load;
   logic             mult_step;
   logic             mult_last;
   logic [WIDTH-1:0] mult_acc_next;

   assign mult_load = (state_q == ST_IDLE) && START && (ALUOP == OP_MUL);
   assign mult_step = (state_q == ST_MUL);

   alu_mult_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mult (
      .clk_i      (CLK),
      .resetn_i   (RESET),
      .load_i     (mult_load),
      .step_i     (mult_step),
      .a_i        (DATA1),
      .b_i        (DATA2),
      .acc_next_o (mult_acc_next),
      .last_o     (mult_last)
   );

   // Zero and out-of-range shift amounts resolve in IDLE without entering SHIFT
   assign imm_shift = (DATA2 == '0) || (DATA2 >= W_LIM);
   assign imm_res   = (DATA2 == '0) ? DATA1 : '0;
   assign shadow_d  = shl_q ? {shadow_q[WIDTH-2:0], 1'b0} : {1'b0, shadow_q[WIDTH-1:1]};

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         sel_q      <= OP_FWD;
         mult_res_q <= '0;
         sl_res_q   <= '0;
         sr_res_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         shadow_q   <= '0;
         scnt_q     <= '0;
         shl_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  case (ALUOP)
                     OP_FWD, OP_ADD, OP_AND, OP_OR: begin
                        sel_q  <= ALUOP;
                        done_q <= 1'b1;
                     end
                     OP_MUL: begin
                        sel_q   <= ALUOP;
                        busy_q  <= 1'b1;
                        state_q <= ST_MUL;
                     end
                     OP_SL, OP_SR: begin
                        sel_q <= ALUOP;
                        if (imm_shift) begin
                           if (ALUOP == OP_SL) sl_res_q <= imm_res;
                           else                sr_res_q <= imm_res;
                           done_q <= 1'b1;
                        end else begin
                           shadow_q <= DATA1;
                           scnt_q   <= DATA2[CNT_W-1:0];
                           shl_q    <= (ALUOP == OP_SL);
                           busy_q   <= 1'b1;
                           state_q  <= ST_SHIFT;
                        end
                     end
                     default: begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                     end
                  endcase
               end
            end
            ST_MUL: begin
               if (mult_last) begin
                  mult_res_q <= mult_acc_next;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               shadow_q <= shadow_d;
               scnt_q   <= scnt_q - CNT_ONE;
               if (scnt_q == CNT_ONE) begin
                  if (shl_q) sl_res_q <= shadow_d;
                  else       sr_res_q <= shadow_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign SEL      = sel_q;
   assign MULT_RES = mult_res_q;
   assign SL_RES   = sl_res_q;
   assign SR_RES   = sr_res_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized checks of alu_seq_ctrl against an arithmetic model
module tb_alu_seq_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [2:0] ALUOP;
   logic [7:0] DATA1;
   logic [7:0] DATA2;
   logic [2:0] SEL;
   logic [7:0] MULT_RES;
   logic [7:0] SL_RES;
   logic [7:0] SR_RES;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   alu_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .ALUOP    (ALUOP),
      .DATA1    (DATA1),
      .DATA2    (DATA2),
      .SEL      (SEL),
      .MULT_RES (MULT_RES),
      .SL_RES   (SL_RES),
      .SR_RES   (SR_RES),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   // Reference: results computed with plain arithmetic, latency as a countdown of edges
   logic [2:0] m_sel = 3'd0;
   logic [7:0] m_mr = 8'd0, m_sl = 8'd0, m_sr = 8'd0, m_pend = 8'd0;
   bit         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
   int         m_rem = 0;
   int         m_kind = 0;

   always @(posedge CLK) begin
      int d1, d2, op, res;
      d1 = int'(DATA1);
      d2 = int'(DATA2);
      op = int'(ALUOP);
      if (!RESET) begin
         m_sel = 3'd0; m_mr = 8'd0; m_sl = 8'd0; m_sr = 8'd0;
         m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_rem = 0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               if (m_kind == 4)      m_mr = m_pend;
               else if (m_kind == 5) m_sl = m_pend;
               else                  m_sr = m_pend;
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (START) begin
            if (op <= 3) begin
               m_sel = 3'(op); m_done = 1'b1;
            end else if (op == 7) begin
               m_done = 1'b1; m_err = 1'b1;
            end else if (op == 4) begin
               m_sel = 3'(op); m_kind = 4; m_pend = 8'((d1 * d2) & 255);
               m_rem = 8; m_busy = 1'b1;
            end else begin
               m_sel = 3'(op); m_kind = op;
               res = (d2 >= 8) ? 0 : ((op == 5) ? ((d1 << d2) & 255) : (d1 >> d2));
               if (d2 == 0 || d2 >= 8) begin
                  if (op == 5) m_sl = 8'(res); else m_sr = 8'(res);
                  m_done = 1'b1;
               end else begin
                  m_pend = 8'(res); m_rem = d2; m_busy = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         checks++;
         if ({SEL, MULT_RES, SL_RES, SR_RES, BUSY, DONE, ERR} !==
             {m_sel, m_mr, m_sl, m_sr, m_busy, m_done, m_err}) begin
            errors++;
            $display("FAIL model t=%0t act sel=%h mr=%h sl=%h sr=%h b=%b d=%b e=%b exp sel=%h mr=%h sl=%h sr=%h b=%b d=%b e=%b",
                     $time, SEL, MULT_RES, SL_RES, SR_RES, BUSY, DONE, ERR,
                     m_sel, m_mr, m_sl, m_sr, m_busy, m_done, m_err);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Returns at the negedge following E0
   task automatic start_op(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2);
      @(negedge CLK);
      START = 1'b1; ALUOP = op; DATA1 = d1; DATA2 = d2;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // lat = k when DONE follows edge Ek of the request issued by start_op
   task automatic wait_done(output int lat);
      lat = 0;
      while (DONE !== 1'b1 && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      if (DONE !== 1'b1) lat = -1;
   endtask

   initial begin
      int lat;
      int dcount;
      RESET = 1'b0; START = 1'b0; ALUOP = 3'd0; DATA1 = 8'd0; DATA2 = 8'd0;
      repeat (3) @(negedge CLK);
      chk("reset_sel", 32'(SEL), 0);
      chk("reset_res", {8'd0, MULT_RES, SL_RES, SR_RES}, 0);
      chk("reset_flags", {29'd0, BUSY, DONE, ERR}, 0);
      chk_en = 1'b1;
      RESET  = 1'b1;

      start_op(3'b001, 8'd5, 8'd3);
      chk("add_done", {30'd0, DONE, BUSY}, 32'h2);
      chk("add_sel", 32'(SEL), 1);
      chk("add_res", {8'd0, MULT_RES, SL_RES, SR_RES}, 0);

      start_op(3'b100, 8'd13, 8'd11);
      chk("mul1_busy", 32'(BUSY), 1);
      wait_done(lat);
      chk("mul1_lat", lat, 8);
      chk("mul1_res", 32'(MULT_RES), 32'h8F);
      chk("mul1_sel", 32'(SEL), 4);
      @(negedge CLK);
      chk("mul1_done_pulse", {30'd0, DONE, BUSY}, 0);

      start_op(3'b100, 8'd20, 8'd20);
      wait_done(lat);
      chk("mul2_lat", lat, 8);
      chk("mul2_res", 32'(MULT_RES), 32'h90);

      start_op(3'b101, 8'h81, 8'd3);
      wait_done(lat);
      chk("sl_lat", lat, 3);
      chk("sl_res", 32'(SL_RES), 32'h08);
      start_op(3'b110, 8'h80, 8'd9);
      wait_done(lat);
      chk("sr_big_lat", lat, 0);
      chk("sr_big_res", {16'd0, SR_RES, SL_RES}, 32'h0008);

      start_op(3'b100, 8'hFF, 8'h02);
      repeat (2) @(negedge CLK);
      START = 1'b1; ALUOP = 3'b001; DATA1 = 8'h00; DATA2 = 8'h00;
      @(negedge CLK);
      START = 1'b0;
      chk("busy_start_ign", {29'd0, SEL}, 4);
      wait_done(lat);
      chk("busy_lat", lat, 5);
      chk("busy_res", {24'd0, MULT_RES}, 32'hFE);
      chk("busy_sel", 32'(SEL), 4);

      start_op(3'b100, 8'd7, 8'd9);
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      chk("abort_state", {20'd0, BUSY, SEL, MULT_RES}, 0);
      dcount = 0;
      repeat (8) begin
         @(negedge CLK);
         if (DONE === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);

      start_op(3'b100, 8'd3, 8'd5);
      wait_done(lat);
      start_op(3'b111, 8'd1, 8'd1);
      chk("ill_pulse", {29'd0, DONE, ERR, BUSY}, 32'h6);
      chk("ill_hold", {21'd0, SEL, MULT_RES}, {21'd0, 3'd4, 8'h0F});
      @(negedge CLK);
      chk("ill_one_cycle", {30'd0, DONE, ERR}, 0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         START = ($urandom_range(0, 2) == 0);
         ALUOP = 3'($urandom);
         DATA1 = 8'($urandom);
         DATA2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
         RESET = ($urandom_range(0, 299) != 0);
      end
      @(negedge CLK);
      RESET = 1'b1; START = 1'b0;
      repeat (12) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Control-side counterpart of the 8-to-1 ALU result selector.
- Accepts an ALU operation request (START, ALUOP, DATA1, DATA2) with a start/busy/done handshake.
- Drives the selector's 3-bit SEL code and produces the multi-cycle results it selects among: iterative multiply, variable shift-left, variable shift-right.
- Sits between the instruction decoder and the ALU output mux; forward/add/and/or results come from existing combinational units, so this block only sequences SEL for them.

Parameters:
- WIDTH, 8, datapath width of DATA1/DATA2/results.
- CNT_W, 4, width of the iteration/shift counter; must hold WIDTH.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  request strobe, sampled only in IDLE.
- ALUOP  in  3  operation: 000 fwd, 001 add, 010 and, 011 or, 100 mult, 101 sl, 110 sr, 111 illegal.
- DATA1  in  WIDTH  operand 1; multiplicand or value to shift.
- DATA2  in  WIDTH  operand 2; multiplier or shift amount (unsigned).
- SEL  out  3  select code to the ALU output mux.
- MULT_RES  out  WIDTH  low WIDTH bits of DATA1*DATA2.
- SL_RES  out  WIDTH  DATA1 logical-shifted left by DATA2.
- SR_RES  out  WIDTH  DATA1 logical-shifted right by DATA2.
- BUSY  out  1  high while a multi-cycle operation is in progress.
- DONE  out  1  one-cycle pulse; SEL and the relevant result are valid while it is high.
- ERR  out  1  one-cycle pulse coincident with DONE for ALUOP=111.

Behaviour:
- Reset (RESET=0 at a rising edge): state IDLE; SEL=000; MULT_RES, SL_RES, SR_RES = 0; BUSY=0; DONE=0; ERR=0; counter and operand shadows cleared.
- Reset mid-operation aborts it immediately. No DONE is issued and results return to 0.
- Naming: E0 is the edge at which START=1 is sampled in IDLE. "DONE at Ek" means DONE is high for the single cycle following edge Ek.
- States: IDLE, MUL, SHIFT.
- IDLE, START=0: all outputs hold, except DONE and ERR, which are 0.
- IDLE, START=1, ALUOP 000..011: at E0, SEL<=ALUOP and DONE at E0. Stay in IDLE; BUSY stays 0.
- IDLE, START=1, ALUOP=111: at E0, DONE and ERR at E0. SEL and all results hold.
- IDLE, START=1, ALUOP=100: at E0, SEL<=100. Load multiplicand=DATA1, multiplier=DATA2, acc=0, count=WIDTH; BUSY<=1; go to MUL.
- MUL, each edge:
  - if multiplier[0], acc<=acc+multiplicand (mod 2^WIDTH);
  - multiplicand<<=1; multiplier>>=1; count-=1.
  - The iteration that takes count to 0 writes MULT_RES<=final acc, BUSY<=0, DONE at that edge, and returns to IDLE.
  - Fixed latency: DONE at E8 for WIDTH=8. No early termination.
- IDLE, START=1, ALUOP=101/110: at E0, SEL<=ALUOP.
  - DATA2=0: result = DATA1, DONE at E0, no SHIFT state.
  - DATA2>=WIDTH: result = 0, DONE at E0, no SHIFT state.
  - Otherwise: load shadow=DATA1, count=DATA2; BUSY<=1; go to SHIFT.
- SHIFT, each edge: shadow shifts 1 bit (zero fill; left for 101, right for 110); count-=1.
  - The shift that takes count to 0 writes the final shadow to SL_RES or SR_RES, BUSY<=0, DONE at that edge, and returns to IDLE.
  - Latency: DONE at EN for shift amount N.
- Result holding: each result register holds its last value until the next completion of its own op. The other two are untouched.
- Operand capture: DATA1, DATA2 and ALUOP are captured only at E0. Changes while BUSY are ignored.
- START while BUSY is ignored: no queueing, no error.
- START coincident with DONE (last busy edge) is ignored. The earliest new START is sampled at the edge after DONE.
- DONE and ERR are never high for more than one consecutive cycle per request.

Decomposition:
- Shared package alu_pkg:
  - ALUOP localparams OP_FWD..OP_SR, OP_ILL = 3'b111;
  - state encoding (IDLE, MUL, SHIFT);
  - WIDTH default.
- The SEL codes must match the selector's case items exactly, so both blocks take them from alu_pkg.
- One natural sub-module: alu_mult_iter, the shift-add multiplier datapath (load, step, count, acc). It is controlled by the parent FSM and reused for any future wider multiply.
- Shifts stay inline in the parent.

Test Plan:
- Reset, then START with ALUOP=001, DATA1=5, DATA2=3 -> SEL=001 and DONE at E0; BUSY stays 0; all results 0.
- START, ALUOP=100, 13x11 -> BUSY high E0..E7, DONE at E8, MULT_RES=0x8F, SEL=100. Repeat with 20x20 -> MULT_RES=0x90 (truncated).
- START, ALUOP=101, DATA1=0x81, DATA2=3 -> DONE at E3, SL_RES=0x08. Then ALUOP=110, DATA1=0x80, DATA2=9 -> DONE at E0, SR_RES=0x00, SL_RES still 0x08.
- START, mult 0xFF x 0x02; pulse START with ALUOP=001 at E3 -> ignored; DONE only at E8, MULT_RES=0xFE, SEL=100.
- START mult; drive RESET=0 at E4 -> at E4, BUSY=0, SEL=000, MULT_RES=0; no DONE at E8.
- START, ALUOP=111 -> DONE and ERR high together for exactly one cycle; SEL and results unchanged.
